// File: rtl/bp_me_uce_mem_arbiter_pkg.sv
// Shared types for the UCE memory arbiter: the memory message layout,
// its flat width, and the source id used to tag outstanding commands.
package bp_me_uce_mem_arbiter_pkg;

    localparam int paddr_width_p  = 40;
    localparam int lce_id_width_p = 4;
    localparam int data_width_p   = 64;

    typedef enum logic [3:0] {
        e_mem_msg_rd    = 4'h0,
        e_mem_msg_wr    = 4'h1,
        e_mem_msg_uc_rd = 4'h2,
        e_mem_msg_uc_wr = 4'h3
    } bp_mem_msg_e;

    typedef enum logic [2:0] {
        e_mem_msg_size_1  = 3'h0,
        e_mem_msg_size_2  = 3'h1,
        e_mem_msg_size_4  = 3'h2,
        e_mem_msg_size_8  = 3'h3,
        e_mem_msg_size_16 = 3'h4,
        e_mem_msg_size_32 = 3'h5,
        e_mem_msg_size_64 = 3'h6
    } bp_mem_msg_size_e;

    typedef struct packed {
        bp_mem_msg_e                msg_type;
        logic [paddr_width_p-1:0]   addr;
        bp_mem_msg_size_e           size;
        logic [lce_id_width_p-1:0]  lce_id;
        logic [data_width_p-1:0]    data;
    } bp_cce_mem_msg_s;

    localparam int cce_mem_msg_width_lp = $bits(bp_cce_mem_msg_s);

    typedef enum logic {
        e_src_icache = 1'b0,
        e_src_dcache = 1'b1
    } bp_me_uce_src_e;

endpackage

// File: rtl/bp_me_uce_mem_arbiter_fifo.sv
// Small circular FIFO with valid/ready input and valid/yumi output.
// Ports: clk_i, reset_i (sync, high); data_i/v_i/ready_o in; data_o/v_o/yumi_i out.
// ready_o depends only on occupancy, so a full FIFO refuses an enqueue
// even in a cycle where it also dequeues.
module bp_me_uce_mem_arbiter_fifo #(
    parameter int width_p = 8,
    parameter int els_p   = 2
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [width_p-1:0] data_i,
    input  logic               v_i,
    output logic               ready_o,
    output logic [width_p-1:0] data_o,
    output logic               v_o,
    input  logic               yumi_i
);

    localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int cnt_w_lp = $clog2(els_p + 1);

    logic [width_p-1:0]  mem_q [els_p];
    logic [ptr_w_lp-1:0] rptr_q, rptr_d;
    logic [ptr_w_lp-1:0] wptr_q, wptr_d;
    logic [cnt_w_lp-1:0] cnt_q, cnt_d;
    logic                enq, deq;

    function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
        return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + ptr_w_lp'(1);
    endfunction

    assign ready_o = (cnt_q != cnt_w_lp'(els_p));
    assign v_o     = (cnt_q != '0);
    assign data_o  = mem_q[rptr_q];
    assign enq     = v_i & ready_o;
    assign deq     = yumi_i & v_o;

    always_comb begin
        rptr_d = deq ? ptr_inc(rptr_q) : rptr_q;
        wptr_d = enq ? ptr_inc(wptr_q) : wptr_q;
        cnt_d  = cnt_q;
        if (enq & ~deq) begin
            cnt_d = cnt_q + cnt_w_lp'(1);
        end else if (deq & ~enq) begin
            cnt_d = cnt_q - cnt_w_lp'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rptr_q <= '0;
            wptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            rptr_q <= rptr_d;
            wptr_q <= wptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem_q[wptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/bp_me_uce_mem_arbiter.sv
// Merges I$ and D$ UCE mem_cmd streams onto one memory port and routes
// each in-order mem_resp back to its issuer using a tag FIFO.
// Ports: clk_i, reset_i (sync, high);
//   {icache,dcache}_mem_cmd_{i,v_i,ready_o}   UCE command inputs
//   {icache,dcache}_mem_resp_{o,v_o,yumi_i}   UCE response outputs
//   mem_cmd_{o,v_o,ready_i}                   merged command to memory
//   mem_resp_{i,v_i,yumi_o}                   memory response
module bp_me_uce_mem_arbiter
    import bp_me_uce_mem_arbiter_pkg::*;
#(
    parameter int outstanding_p = 4
) (
    input  logic                            clk_i,
    input  logic                            reset_i,

    input  logic [cce_mem_msg_width_lp-1:0] icache_mem_cmd_i,
    input  logic                            icache_mem_cmd_v_i,
    output logic                            icache_mem_cmd_ready_o,
    output logic [cce_mem_msg_width_lp-1:0] icache_mem_resp_o,
    output logic                            icache_mem_resp_v_o,
    input  logic                            icache_mem_resp_yumi_i,

    input  logic [cce_mem_msg_width_lp-1:0] dcache_mem_cmd_i,
    input  logic                            dcache_mem_cmd_v_i,
    output logic                            dcache_mem_cmd_ready_o,
    output logic [cce_mem_msg_width_lp-1:0] dcache_mem_resp_o,
    output logic                            dcache_mem_resp_v_o,
    input  logic                            dcache_mem_resp_yumi_i,

    output logic [cce_mem_msg_width_lp-1:0] mem_cmd_o,
    output logic                            mem_cmd_v_o,
    input  logic                            mem_cmd_ready_i,

    input  logic [cce_mem_msg_width_lp-1:0] mem_resp_i,
    input  logic                            mem_resp_v_i,
    output logic                            mem_resp_yumi_o
);

    logic [cce_mem_msg_width_lp-1:0] i_data, d_data;
    logic            i_v, i_rdy, i_yumi;
    logic            d_v, d_rdy, d_yumi;
    logic            tag_v, tag_rdy, tag_head, tag_din;
    logic            cand_v, grant, resp_live;
    bp_me_uce_src_e  cand_src, head_src;
    bp_me_uce_src_e  rr_q, rr_d;

    bp_me_uce_mem_arbiter_fifo #(
        .width_p (cce_mem_msg_width_lp),
        .els_p   (2)
    ) i_buf (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .data_i  (icache_mem_cmd_i),
        .v_i     (icache_mem_cmd_v_i),
        .ready_o (i_rdy),
        .data_o  (i_data),
        .v_o     (i_v),
        .yumi_i  (i_yumi)
    );

    bp_me_uce_mem_arbiter_fifo #(
        .width_p (cce_mem_msg_width_lp),
        .els_p   (2)
    ) d_buf (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .data_i  (dcache_mem_cmd_i),
        .v_i     (dcache_mem_cmd_v_i),
        .ready_o (d_rdy),
        .data_o  (d_data),
        .v_o     (d_v),
        .yumi_i  (d_yumi)
    );

    // Ready is occupancy-only, held low while reset is asserted.
    assign icache_mem_cmd_ready_o = i_rdy & ~reset_i;
    assign dcache_mem_cmd_ready_o = d_rdy & ~reset_i;

    always_comb begin
        cand_v   = i_v | d_v;
        cand_src = e_src_icache;
        if (i_v & d_v) begin
            cand_src = rr_q;
        end else if (d_v) begin
            cand_src = e_src_dcache;
        end
    end

    assign mem_cmd_v_o = cand_v & tag_rdy & ~reset_i;
    assign mem_cmd_o   = (cand_src == e_src_dcache) ? d_data : i_data;
    assign grant       = mem_cmd_v_o & mem_cmd_ready_i;
    assign i_yumi      = grant & (cand_src == e_src_icache);
    assign d_yumi      = grant & (cand_src == e_src_dcache);
    assign tag_din     = (cand_src == e_src_dcache);

    // Priority passes to the other source after every grant.
    always_comb begin
        rr_d = rr_q;
        if (grant) begin
            rr_d = (cand_src == e_src_icache) ? e_src_dcache : e_src_icache;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rr_q <= e_src_icache;
        end else begin
            rr_q <= rr_d;
        end
    end

    bp_me_uce_mem_arbiter_fifo #(
        .width_p (1),
        .els_p   (outstanding_p)
    ) tag_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .data_i  (tag_din),
        .v_i     (grant),
        .ready_o (tag_rdy),
        .data_o  (tag_head),
        .v_o     (tag_v),
        .yumi_i  (mem_resp_yumi_o)
    );

    assign head_src  = bp_me_uce_src_e'(tag_head);
    assign resp_live = mem_resp_v_i & tag_v & ~reset_i;

    assign icache_mem_resp_o   = mem_resp_i;
    assign dcache_mem_resp_o   = mem_resp_i;
    assign icache_mem_resp_v_o = resp_live & (head_src == e_src_icache);
    assign dcache_mem_resp_v_o = resp_live & (head_src == e_src_dcache);

    // Only the head source's yumi can retire the response.
    assign mem_resp_yumi_o = (icache_mem_resp_v_o & icache_mem_resp_yumi_i)
                           | (dcache_mem_resp_v_o & dcache_mem_resp_yumi_i);

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!(mem_resp_v_i && !tag_v))
                else $error("mem_resp_v_i with no outstanding command");
            assert (!(icache_mem_resp_yumi_i && !icache_mem_resp_v_o))
                else $error("icache yumi while not head");
            assert (!(dcache_mem_resp_yumi_i && !dcache_mem_resp_v_o))
                else $error("dcache yumi while not head");
            assert (!(icache_mem_cmd_v_i && !icache_mem_cmd_ready_o))
                else $error("icache cmd valid while not ready");
            assert (!(dcache_mem_cmd_v_i && !dcache_mem_cmd_ready_o))
                else $error("dcache cmd valid while not ready");
        end
    end
`endif

endmodule

// File: tb/tb_bp_me_uce_mem_arbiter.sv
// Directed + random bench for bp_me_uce_mem_arbiter against a
// queue-based reference model of buffers, round-robin and tag order.
module tb_bp_me_uce_mem_arbiter;
    import bp_me_uce_mem_arbiter_pkg::*;

    localparam int W   = cce_mem_msg_width_lp;
    localparam int OUT = 4;

    typedef logic [W-1:0] msg_t;

    logic clk;
    logic reset_i;
    msg_t icache_mem_cmd_i, dcache_mem_cmd_i;
    logic icache_mem_cmd_v_i, dcache_mem_cmd_v_i;
    logic icache_mem_cmd_ready_o, dcache_mem_cmd_ready_o;
    msg_t icache_mem_resp_o, dcache_mem_resp_o;
    logic icache_mem_resp_v_o, dcache_mem_resp_v_o;
    logic icache_mem_resp_yumi_i, dcache_mem_resp_yumi_i;
    msg_t mem_cmd_o;
    logic mem_cmd_v_o, mem_cmd_ready_i;
    msg_t mem_resp_i;
    logic mem_resp_v_i, mem_resp_yumi_o;

    bp_me_uce_mem_arbiter #(.outstanding_p(OUT)) dut (
        .clk_i                  (clk),
        .reset_i                (reset_i),
        .icache_mem_cmd_i       (icache_mem_cmd_i),
        .icache_mem_cmd_v_i     (icache_mem_cmd_v_i),
        .icache_mem_cmd_ready_o (icache_mem_cmd_ready_o),
        .icache_mem_resp_o      (icache_mem_resp_o),
        .icache_mem_resp_v_o    (icache_mem_resp_v_o),
        .icache_mem_resp_yumi_i (icache_mem_resp_yumi_i),
        .dcache_mem_cmd_i       (dcache_mem_cmd_i),
        .dcache_mem_cmd_v_i     (dcache_mem_cmd_v_i),
        .dcache_mem_cmd_ready_o (dcache_mem_cmd_ready_o),
        .dcache_mem_resp_o      (dcache_mem_resp_o),
        .dcache_mem_resp_v_o    (dcache_mem_resp_v_o),
        .dcache_mem_resp_yumi_i (dcache_mem_resp_yumi_i),
        .mem_cmd_o              (mem_cmd_o),
        .mem_cmd_v_o            (mem_cmd_v_o),
        .mem_cmd_ready_i        (mem_cmd_ready_i),
        .mem_resp_i             (mem_resp_i),
        .mem_resp_v_i           (mem_resp_v_i),
        .mem_resp_yumi_o        (mem_resp_yumi_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: per-source command queues, issuer queue of
    // outstanding commands, and which source wins the next tie.
    msg_t iq[$];
    msg_t dq[$];
    bit   tq[$];
    bit   tie_d;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input msg_t obs, input msg_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic msg_t rnd_msg();
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return r[W-1:0];
    endfunction

    function automatic msg_t mk(input bp_mem_msg_e t, input logic [39:0] a);
        bp_cce_mem_msg_s m;
        m          = '0;
        m.msg_type = t;
        m.addr     = a;
        m.size     = e_mem_msg_size_8;
        m.data     = {$urandom, $urandom};
        return m;
    endfunction

    // One clock: drive legal inputs, check outputs, advance model.
    task automatic step(input logic rst,
                        input logic iv, input msg_t im,
                        input logic dv, input msg_t dm,
                        input logic mrdy, input logic rv,
                        input logic iy, input logic dy);
        logic xi_rdy, xd_rdy, have_tag, head, xiv, xdv, xv, xy, cand;
        xi_rdy   = !rst && iq.size() < 2;
        xd_rdy   = !rst && dq.size() < 2;
        have_tag = tq.size() > 0;
        head     = have_tag ? tq[0] : 1'b0;

        reset_i                = rst;
        icache_mem_cmd_v_i     = iv & xi_rdy;
        icache_mem_cmd_i       = im;
        dcache_mem_cmd_v_i     = dv & xd_rdy;
        dcache_mem_cmd_i       = dm;
        mem_cmd_ready_i        = mrdy;
        mem_resp_v_i           = rv & have_tag & !rst;
        mem_resp_i             = rnd_msg();
        xiv                    = mem_resp_v_i & !head;
        xdv                    = mem_resp_v_i & head;
        icache_mem_resp_yumi_i = iy & xiv;
        dcache_mem_resp_yumi_i = dy & xdv;
        xy = icache_mem_resp_yumi_i | dcache_mem_resp_yumi_i;

        if (iq.size() > 0 && dq.size() > 0) cand = tie_d;
        else cand = (iq.size() == 0);
        xv = !rst && (iq.size() + dq.size() > 0) && tq.size() < OUT;

        #1;
        chk("i_ready", msg_t'(icache_mem_cmd_ready_o), msg_t'(xi_rdy));
        chk("d_ready", msg_t'(dcache_mem_cmd_ready_o), msg_t'(xd_rdy));
        chk("cmd_v", msg_t'(mem_cmd_v_o), msg_t'(xv));
        if (xv) chk("cmd_data", mem_cmd_o, cand ? dq[0] : iq[0]);
        chk("i_resp_v", msg_t'(icache_mem_resp_v_o), msg_t'(xiv));
        chk("d_resp_v", msg_t'(dcache_mem_resp_v_o), msg_t'(xdv));
        chk("resp_yumi", msg_t'(mem_resp_yumi_o), msg_t'(xy));
        if (xiv) chk("i_resp_data", icache_mem_resp_o, mem_resp_i);
        if (xdv) chk("d_resp_data", dcache_mem_resp_o, mem_resp_i);

        if (rst) begin
            iq.delete();
            dq.delete();
            tq.delete();
            tie_d = 1'b0;
        end else begin
            if (xy) void'(tq.pop_front());
            if (xv && mrdy) begin
                if (cand) void'(dq.pop_front());
                else void'(iq.pop_front());
                tq.push_back(cand);
                tie_d = !cand;
            end
            if (icache_mem_cmd_v_i) iq.push_back(im);
            if (dcache_mem_cmd_v_i) dq.push_back(dm);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic mrdy, input logic rv, input logic iy, input logic dy);
        step(1'b0, 1'b0, '0, 1'b0, '0, mrdy, rv, iy, dy);
    endtask

    initial begin
        int sent;
        tie_d = 1'b0;

        // Reset and first cycle after reset
        step(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1'b1, 1'b0, 1'b0, 1'b0);

        // Single I$ read, visible one cycle after acceptance
        step(1'b0, 1'b1, mk(e_mem_msg_rd, 40'h00_8000_0040),
             1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b1);
        idle(1'b1, 1'b0, 1'b1, 1'b1);
        idle(1'b1, 1'b1, 1'b1, 1'b1);

        // Simultaneous pairs: I$ first both times
        step(1'b0, 1'b1, rnd_msg(), 1'b1, rnd_msg(), 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1'b1, 1'b0, 1'b0, 1'b0);
        idle(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, rnd_msg(), 1'b1, rnd_msg(), 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1'b1, 1'b0, 1'b0, 1'b0);
        idle(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) idle(1'b1, 1'b1, 1'b1, 1'b1);

        // D$ issues 5 uncached writes with no responses
        sent = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, '0, sent < 5,
                 mk(e_mem_msg_uc_wr, 40'h00_9000_0000 + 40'(sent * 8)),
                 1'b1, 1'b0, 1'b0, 1'b0);
            if (dcache_mem_cmd_v_i) sent++;
        end
        idle(1'b1, 1'b1, 1'b0, 1'b1);
        idle(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) idle(1'b1, 1'b1, 1'b0, 1'b1);

        // Responses I$, D$, I$ with D$ yumi delayed
        step(1'b0, 1'b1, rnd_msg(), 1'b1, rnd_msg(), 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, rnd_msg(), 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1'b1, 1'b0, 1'b0, 1'b0);
        idle(1'b1, 1'b0, 1'b0, 1'b0);
        idle(1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) idle(1'b1, 1'b1, 1'b1, 1'b0);
        idle(1'b1, 1'b1, 1'b1, 1'b1);
        idle(1'b1, 1'b1, 1'b1, 1'b1);

        // Memory stalled while both sources stream
        for (int i = 0; i < 12; i++)
            step(1'b0, 1'b1, rnd_msg(), 1'b1, rnd_msg(), i >= 10, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) idle(1'b1, 1'b1, 1'b1, 1'b1);

        // Reset with 2 outstanding and full buffers
        step(1'b0, 1'b1, rnd_msg(), 1'b1, rnd_msg(), 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1'b1, 1'b0, 1'b0, 1'b0);
        idle(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, rnd_msg(), 1'b1, rnd_msg(), 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, rnd_msg(), 1'b1, rnd_msg(), 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, rnd_msg(), 1'b1, rnd_msg(), 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1'b1, 1'b0, 1'b0, 1'b0);
        idle(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) idle(1'b1, 1'b1, 1'b1, 1'b1);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 2) != 0, rnd_msg(),
                 $urandom_range(0, 2) != 0, rnd_msg(),
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, 2) != 0,
                 $urandom_range(0, 2) != 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
